// File: rtl/ppu_tile_render_fsm.sv
// Purpose : renders one 8x8 background tile plus NUM_SPRITES sprite slots into a pixel write port.
// Latency : 2(RD_LATENCY+1) + 8*(2(RD_LATENCY+1)(1+NUM_SPRITES) + 8) + 1 cycles from start to done.
// Backpressure: none; start is ignored while busy and VRAM/VGA ports are never stalled.
//
// Ports:
//   clk, rst                     clock, async active-low reset
//   start                        one-cycle render request (ignored while busy)
//   curr_row/curr_col            screen position of the tile's top-left pixel
//   nametable_ptr/attr_ptr       tile-number and attribute byte addresses
//   attr_shift                   bit position of the 2-bit palette select in the attribute byte
//   *_pattern_base               pattern table bases for background and sprites
//   ppu_ctrl2                    layer enables (bit3 bg, bit4 spr) and left-edge show bits (bit1 bg, bit2 spr)
//   sprite_*                     per-slot sprite descriptors, slot k in bits [8k+7:8k]
//   background/sprite_colors     16-entry palettes, entry i in bits [8i+7:8i]
//   vram_addr/vram_data_in       VRAM read port, data valid RD_LATENCY cycles after the address
//   vga_ram_*/vga_write_en       pixel write port
//   busy/done/sprite0_hit        status: render in progress, completion pulse, sticky sprite-0 hit
module ppu_tile_render_fsm #(
   parameter int NUM_SPRITES = 4,
   parameter int RD_LATENCY  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [8:0]               curr_row,
   input  logic [8:0]               curr_col,
   input  logic [15:0]              nametable_ptr,
   input  logic [15:0]              attr_ptr,
   input  logic [2:0]               attr_shift,
   input  logic [15:0]              background_pattern_base,
   input  logic [15:0]              sprite_pattern_base,
   input  logic [7:0]               ppu_ctrl2,
   input  logic [NUM_SPRITES-1:0]   sprite_valid,
   input  logic [8*NUM_SPRITES-1:0] sprite_tile_nums,
   input  logic [8*NUM_SPRITES-1:0] sprite_rows,
   input  logic [8*NUM_SPRITES-1:0] sprite_cols,
   input  logic [8*NUM_SPRITES-1:0] sprite_attrs,
   input  logic [127:0]             background_colors,
   input  logic [127:0]             sprite_colors,
   output logic [15:0]              vram_addr,
   input  logic [7:0]               vram_data_in,
   output logic [8:0]               vga_ram_row,
   output logic [8:0]               vga_ram_col,
   output logic [7:0]               vga_ram_data,
   output logic                     vga_write_en,
   output logic                     busy,
   output logic                     done,
   output logic                     sprite0_hit
);

   localparam int                SLOT_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SPRITES - 1);
   localparam logic [1:0]        LAST_WAIT = 2'(RD_LATENCY);

   typedef enum logic [3:0] {
      IDLE, FETCH_NT, FETCH_AT, BG_LO, BG_HI, SPR_LO, SPR_HI, EMIT, DONE
   } state_t;

   state_t            state;
   logic [1:0]        wcnt;      // cycles spent in the current fetch state
   logic [2:0]        row_r;     // fine row within the tile
   logic [2:0]        pix;       // pixel column during EMIT
   logic [SLOT_W-1:0] slot;      // sprite slot being fetched
   logic [7:0]        tile_num;
   logic [1:0]        pal_sel;
   logic [7:0]        bg_lo;
   logic [7:0]        bg_hi;
   logic [7:0]        spr_lo [NUM_SPRITES];
   logic [7:0]        spr_hi [NUM_SPRITES];

   logic              fetch_last;
   logic [8:0]        x_pos;
   logic              left_edge;
   logic [1:0]        bg_px;
   logic [1:0]        kpx;
   logic [1:0]        win_px;
   logic [1:0]        win_pal;
   logic              win_behind;
   logic [1:0]        s0_px;
   logic [7:0]        pix_colour;
   logic              hit_now;

   // ppu_ctrl2 bits 0/5-7 and sprite attr bits 2-4 carry no meaning for this renderer.
   logic              cfg_unused;
   assign cfg_unused = ^{ppu_ctrl2[7:5], ppu_ctrl2[0], sprite_attrs};

   // Data for a fetch is captured on the last of its RD_LATENCY+1 cycles.
   assign fetch_last = (wcnt == LAST_WAIT);

   // Screen row of fine row r relative to sprite k's top; in range 0..7 when the sprite covers it.
   function automatic logic [8:0] spr_row_delta(input logic [SLOT_W-1:0] k, input logic [2:0] r);
      return curr_row + {6'd0, r} - {1'b0, sprite_rows[{k, 3'b000} +: 8]};
   endfunction

   function automatic logic [15:0] bg_addr(input logic [2:0] r, input logic hi);
      return background_pattern_base + {4'd0, tile_num, 4'd0} + {13'd0, r} + {12'd0, hi, 3'd0};
   endfunction

   // Every slot is fetched whether or not it covers the row, keeping the latency fixed.
   function automatic logic [15:0] spr_addr(input logic [SLOT_W-1:0] k, input logic [2:0] r,
                                            input logic hi);
      logic [8:0] d;
      logic [2:0] fr;
      d  = spr_row_delta(k, r);
      fr = sprite_attrs[{k, 3'b111}] ? ~d[2:0] : d[2:0];
      return sprite_pattern_base + {4'd0, sprite_tile_nums[{k, 3'b000} +: 8], 4'd0}
             + {13'd0, fr} + {12'd0, hi, 3'd0};
   endfunction

   // Raw 2-bit sprite pixel before layer enable / left-edge clipping.
   function automatic logic [1:0] spr_pixel(input logic [SLOT_W-1:0] k, input logic [2:0] r,
                                            input logic [2:0] c);
      logic [8:0] d;
      logic [8:0] sc;
      logic [2:0] b;
      logic [1:0] px;
      d  = spr_row_delta(k, r);
      sc = curr_col + {6'd0, c} - {1'b0, sprite_cols[{k, 3'b000} +: 8]};
      b  = sprite_attrs[{k, 3'b110}] ? sc[2:0] : 3'd7 - sc[2:0];
      px = {spr_hi[k][b], spr_lo[k][b]};
      if (!sprite_valid[k] || d[8:3] != 6'd0 || sc[8:3] != 6'd0)
         px = 2'd0;
      return px;
   endfunction

   // Pixel mux for the EMIT column currently addressed by pix.
   always_comb begin
      x_pos      = curr_col + {6'd0, pix};
      left_edge  = (x_pos < 9'd8);
      bg_px      = {bg_hi[3'd7 - pix], bg_lo[3'd7 - pix]};
      if (!ppu_ctrl2[3] || (left_edge && !ppu_ctrl2[1]))
         bg_px = 2'd0;
      kpx        = 2'd0;
      win_px     = 2'd0;
      win_pal    = 2'd0;
      win_behind = 1'b0;
      s0_px      = 2'd0;
      for (int k = 0; k < NUM_SPRITES; k++) begin
         kpx = spr_pixel(SLOT_W'(k), row_r, pix);
         if (!ppu_ctrl2[4] || (left_edge && !ppu_ctrl2[2]))
            kpx = 2'd0;
         if (k == 0)
            s0_px = kpx;
         // Lowest-numbered opaque slot wins.
         if (win_px == 2'd0 && kpx != 2'd0) begin
            win_px     = kpx;
            win_pal    = sprite_attrs[8*k +: 2];
            win_behind = sprite_attrs[8*k + 5];
         end
      end
      if (win_px != 2'd0 && (!win_behind || bg_px == 2'd0))
         pix_colour = sprite_colors[{win_pal, win_px, 3'b000} +: 8];
      else if (bg_px != 2'd0)
         pix_colour = background_colors[{pal_sel, bg_px, 3'b000} +: 8];
      else
         pix_colour = background_colors[7:0];
      // Hit ignores priority: only opacity of slot 0 and background matters.
      hit_now = (s0_px != 2'd0) && (bg_px != 2'd0) && (x_pos != 9'd255);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         wcnt         <= 2'd0;
         row_r        <= 3'd0;
         pix          <= 3'd0;
         slot         <= '0;
         tile_num     <= 8'd0;
         pal_sel      <= 2'd0;
         bg_lo        <= 8'd0;
         bg_hi        <= 8'd0;
         for (int k = 0; k < NUM_SPRITES; k++) begin
            spr_lo[k] <= 8'd0;
            spr_hi[k] <= 8'd0;
         end
         vram_addr    <= 16'd0;
         vga_ram_row  <= 9'd0;
         vga_ram_col  <= 9'd0;
         vga_ram_data <= 8'd0;
         vga_write_en <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sprite0_hit  <= 1'b0;
      end else begin
         done         <= 1'b0;
         vga_write_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= FETCH_NT;
                  busy        <= 1'b1;
                  sprite0_hit <= 1'b0;
                  wcnt        <= 2'd0;
                  row_r       <= 3'd0;
                  pix         <= 3'd0;
                  slot        <= '0;
                  vram_addr   <= nametable_ptr;
               end
            end
            FETCH_NT: begin
               if (fetch_last) begin
                  tile_num  <= vram_data_in;
                  state     <= FETCH_AT;
                  wcnt      <= 2'd0;
                  vram_addr <= attr_ptr;
               end else begin
                  wcnt <= wcnt + 2'd1;
               end
            end
            FETCH_AT: begin
               if (fetch_last) begin
                  pal_sel   <= 2'(vram_data_in >> attr_shift);
                  state     <= BG_LO;
                  wcnt      <= 2'd0;
                  vram_addr <= bg_addr(3'd0, 1'b0);
               end else begin
                  wcnt <= wcnt + 2'd1;
               end
            end
            BG_LO: begin
               if (fetch_last) begin
                  bg_lo     <= vram_data_in;
                  state     <= BG_HI;
                  wcnt      <= 2'd0;
                  vram_addr <= bg_addr(row_r, 1'b1);
               end else begin
                  wcnt <= wcnt + 2'd1;
               end
            end
            BG_HI: begin
               if (fetch_last) begin
                  bg_hi     <= vram_data_in;
                  state     <= SPR_LO;
                  wcnt      <= 2'd0;
                  slot      <= '0;
                  vram_addr <= spr_addr('0, row_r, 1'b0);
               end else begin
                  wcnt <= wcnt + 2'd1;
               end
            end
            SPR_LO: begin
               if (fetch_last) begin
                  spr_lo[slot] <= vram_data_in;
                  state        <= SPR_HI;
                  wcnt         <= 2'd0;
                  vram_addr    <= spr_addr(slot, row_r, 1'b1);
               end else begin
                  wcnt <= wcnt + 2'd1;
               end
            end
            SPR_HI: begin
               if (fetch_last) begin
                  spr_hi[slot] <= vram_data_in;
                  wcnt         <= 2'd0;
                  if (slot == LAST_SLOT) begin
                     state <= EMIT;
                     pix   <= 3'd0;
                  end else begin
                     slot      <= slot + 1'b1;
                     state     <= SPR_LO;
                     vram_addr <= spr_addr(slot + 1'b1, row_r, 1'b0);
                  end
               end else begin
                  wcnt <= wcnt + 2'd1;
               end
            end
            EMIT: begin
               vga_write_en <= 1'b1;
               vga_ram_row  <= curr_row + {6'd0, row_r};
               vga_ram_col  <= x_pos;
               vga_ram_data <= pix_colour;
               if (hit_now)
                  sprite0_hit <= 1'b1;
               pix <= pix + 3'd1;
               if (pix == 3'd7) begin
                  if (row_r == 3'd7) begin
                     state <= DONE;
                  end else begin
                     row_r     <= row_r + 3'd1;
                     state     <= BG_LO;
                     wcnt      <= 2'd0;
                     vram_addr <= bg_addr(row_r + 3'd1, 1'b0);
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ppu_tile_render_fsm.sv
// Purpose : scoreboard bench for ppu_tile_render_fsm with a latency-1 VRAM model.
// Latency : expects done 229 cycles after the start edge at default parameters.
// Backpressure: none; the monitor pops one expected pixel per observed write.
module tb_ppu_tile_render_fsm;

   localparam int NS = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [8:0]      curr_row, curr_col;
   logic [15:0]     nametable_ptr, attr_ptr;
   logic [2:0]      attr_shift;
   logic [15:0]     background_pattern_base, sprite_pattern_base;
   logic [7:0]      ppu_ctrl2;
   logic [NS-1:0]   sprite_valid;
   logic [8*NS-1:0] sprite_tile_nums, sprite_rows, sprite_cols, sprite_attrs;
   logic [127:0]    background_colors, sprite_colors;
   logic [15:0]     vram_addr;
   logic [7:0]      vram_data_in;
   logic [8:0]      vga_ram_row, vga_ram_col;
   logic [7:0]      vga_ram_data;
   logic            vga_write_en, busy, done, sprite0_hit;

   typedef struct packed {
      logic [8:0] row;
      logic [8:0] col;
      logic [7:0] dat;
   } pix_t;

   pix_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;
   logic [7:0]  vram [0:65535];

   ppu_tile_render_fsm dut (
      .clk(clk), .rst(rst), .start(start),
      .curr_row(curr_row), .curr_col(curr_col),
      .nametable_ptr(nametable_ptr), .attr_ptr(attr_ptr), .attr_shift(attr_shift),
      .background_pattern_base(background_pattern_base),
      .sprite_pattern_base(sprite_pattern_base),
      .ppu_ctrl2(ppu_ctrl2), .sprite_valid(sprite_valid),
      .sprite_tile_nums(sprite_tile_nums), .sprite_rows(sprite_rows),
      .sprite_cols(sprite_cols), .sprite_attrs(sprite_attrs),
      .background_colors(background_colors), .sprite_colors(sprite_colors),
      .vram_addr(vram_addr), .vram_data_in(vram_data_in),
      .vga_ram_row(vga_ram_row), .vga_ram_col(vga_ram_col),
      .vga_ram_data(vga_ram_data), .vga_write_en(vga_write_en),
      .busy(busy), .done(done), .sprite0_hit(sprite0_hit)
   );

   always #5 clk = ~clk;

   // VRAM with one cycle of read latency.
   always @(posedge clk) vram_data_in <= vram[vram_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   // Monitor: every observed pixel write is matched against the scoreboard head.
   always @(negedge clk) begin
      pix_t e;
      if (vga_write_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: row=%0d col=%0d data=%0h", vga_ram_row, vga_ram_col,
                     vga_ram_data);
         end else begin
            e = exp_q.pop_front();
            check("pixel", {6'd0, vga_ram_row, vga_ram_col, vga_ram_data}, {6'd0, e});
         end
      end
   end

   // Hand-derived expected colour per scenario, fine row r and column c.
   function automatic logic [7:0] exp_pix(input int scen, input int r, input int c);
      case (scen)
         1: return 8'hBB;
         2: return (c >= 3) ? 8'hAA : 8'hBB;
         3: return 8'hBB;
         4: return (r < 2 || c < 4) ? 8'hA7 : ((r == 2) ? 8'hA2 : 8'hAA);
         default: return 8'h0B;
      endcase
   endfunction

   task automatic push_tile(input int scen);
      pix_t e;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            e.row = curr_row + 9'(r);
            e.col = curr_col + 9'(c);
            e.dat = exp_pix(scen, r, c);
            exp_q.push_back(e);
         end
   endtask

   task automatic setup(input logic [7:0] ctrl, input logic [8:0] r0, input logic [8:0] c0);
      ppu_ctrl2        = ctrl;
      curr_row         = r0;
      curr_col         = c0;
      sprite_valid     = '0;
      sprite_tile_nums = '0;
      sprite_rows      = '0;
      sprite_cols      = '0;
      sprite_attrs     = '0;
   endtask

   task automatic run_render(input int scen, input logic exp_hit);
      int lat;
      bit got;
      push_tile(scen);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check($sformatf("s%0d_busy_rise", scen), {31'd0, busy}, 32'd1);
      check($sformatf("s%0d_hit_clear", scen), {31'd0, sprite0_hit}, 32'd0);
      lat = 0;
      got = 1'b0;
      while (lat < 1000 && !got) begin
         @(posedge clk);
         lat++;
         #1;
         if (done === 1'b1) got = 1'b1;
         else start = (lat == 50);   // extra start while busy must be ignored
      end
      start = 1'b0;
      check($sformatf("s%0d_done_seen", scen), {31'd0, got}, 32'd1);
      check($sformatf("s%0d_latency", scen), 32'(lat), 32'd229);
      check($sformatf("s%0d_busy_fall", scen), {31'd0, busy}, 32'd0);
      check($sformatf("s%0d_sprite0_hit", scen), {31'd0, sprite0_hit}, {31'd0, exp_hit});
      @(posedge clk);
      #1 check($sformatf("s%0d_done_pulse", scen), {31'd0, done}, 32'd0);
      check($sformatf("s%0d_queue_drained", scen), 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      for (int i = 0; i < 65536; i++) vram[i] = 8'h00;
      for (int i = 0; i < 16; i++) begin
         vram[16'h0010 + i] = 8'hFF;
         vram[16'h1010 + i] = 8'hFF;
      end
      // Sprite tile 2: half-row 0xF0 on both planes, except low-plane row 7 empty.
      for (int i = 0; i < 16; i++) vram[16'h1020 + i] = 8'hF0;
      vram[16'h1027] = 8'h00;
      vram[16'h2000] = 8'h01;
      vram[16'h23C0] = 8'h0C;

      rst                     = 1'b0;
      start                   = 1'b0;
      nametable_ptr           = 16'h2000;
      attr_ptr                = 16'h23C0;
      attr_shift              = 3'd2;
      background_pattern_base = 16'h0000;
      sprite_pattern_base     = 16'h1000;
      background_colors       = {16{8'hBB}};
      background_colors[7:0]  = 8'h0B;
      sprite_colors           = {16{8'hAA}};
      sprite_colors[23:16]    = 8'hA2;
      sprite_colors[63:56]    = 8'hA7;
      setup(8'h0A, 9'd16, 9'd40);

      repeat (2) @(posedge clk);
      #1;
      check("rst_vram_addr", {16'd0, vram_addr}, 32'd0);
      check("rst_vga_pos", {14'd0, vga_ram_row, vga_ram_col}, 32'd0);
      check("rst_vga_data", {24'd0, vga_ram_data}, 32'd0);
      check("rst_flags", {28'd0, vga_write_en, busy, done, sprite0_hit}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // 1: background only, offset tile
      setup(8'h0A, 9'd16, 9'd40);
      run_render(1, 1'b0);

      // 2: sprite slot 0 in front, starting at x=3
      setup(8'h1E, 9'd0, 9'd0);
      sprite_valid[0] = 1'b1;
      sprite_tile_nums[7:0] = 8'd1;
      sprite_cols[7:0] = 8'd3;
      run_render(2, 1'b1);

      // 3: same sprite behind the background
      sprite_attrs[7:0] = 8'h20;
      run_render(3, 1'b1);

      // 4: slot 0 flipped half-row over an opaque slot 1
      setup(8'h1E, 9'd0, 9'd0);
      sprite_valid = 4'b0011;
      sprite_tile_nums[7:0] = 8'd2;
      sprite_rows[7:0] = 8'd2;
      sprite_attrs[7:0] = 8'hC0;
      sprite_tile_nums[15:8] = 8'd1;
      sprite_attrs[15:8] = 8'h01;
      run_render(4, 1'b1);

      // 5: left-edge clip hides both layers
      setup(8'h18, 9'd0, 9'd0);
      sprite_valid[0] = 1'b1;
      sprite_tile_nums[7:0] = 8'd1;
      run_render(5, 1'b0);

      // 6: reset during EMIT of fine row 3, then a clean restart
      setup(8'h0A, 9'd16, 9'd40);
      push_tile(1);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(negedge clk);
         #2;
         if (vga_write_en === 1'b1 && vga_ram_row == 9'd19) seen = 1'b1;
      end
      check("s6_row3_reached", {31'd0, seen}, 32'd1);
      exp_q.delete();
      rst = 1'b0;
      #1;
      check("s6_busy_on_reset", {31'd0, busy}, 32'd0);
      check("s6_wr_on_reset", {31'd0, vga_write_en}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check("s6_idle_after_reset", {30'd0, busy, done}, 32'd0);
      run_render(1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
